// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM encoding and default width for alu_pipe
package alu_pkg;

    localparam int ALU_DEFAULT_WIDTH = 32;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_NOR  = 4'd4;
    localparam logic [3:0] ALU_SLTU = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_MUL  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - operand-issue and result handshake bundle for alu_pipe
interface alu_pipe_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_ovf
    );

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_ovf
    );

endinterface

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier, low WIDTH bits, WIDTH cycles
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [SHW-1:0]   cnt;
    logic             busy;

    // p already folds in the current step, so on the last cycle it is the final product
    assign p    = acc + (mplier[0] ? mcand : '0);
    assign done = busy && (cnt == SHW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= p;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered handshaked ALU; ALU_MUL_EN enables iterative MUL (op 11)
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_DEFAULT_WIDTH
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_pipe_if.slave bus
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic             take;
    logic             load_alu;
    logic [3:0]       op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic [WIDTH-1:0] res_q;
    logic             zero_q, ovf_q;

    // op is forced to a known code when nothing is presented so X never reaches the mux
    assign op    = bus.in_valid ? bus.in_op : ALU_AND;
    assign shamt = bus.in_b[SHW-1:0];
    assign sum   = bus.in_a + bus.in_b;
    assign diff  = bus.in_a - bus.in_b;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            ALU_AND:  alu_res = bus.in_a & bus.in_b;
            ALU_OR:   alu_res = bus.in_a | bus.in_b;
            ALU_XOR:  alu_res = bus.in_a ^ bus.in_b;
            ALU_NOR:  alu_res = ~(bus.in_a | bus.in_b);
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.in_a < bus.in_b)};
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
            ALU_SLL:  alu_res = bus.in_a << shamt;
            ALU_SRL:  alu_res = bus.in_a >> shamt;
            ALU_SRA:  alu_res = WIDTH'($signed(bus.in_a) >>> shamt);
            ALU_SUB: begin
                alu_res = diff;
                alu_ovf = (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1]) &&
                          (diff[WIDTH-1] != bus.in_a[WIDTH-1]);
            end
            default: begin
                alu_res = sum;
                alu_ovf = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.in_a[WIDTH-1]);
            end
        endcase
    end

`ifdef ALU_MUL_EN
    logic             is_mul;
    logic             mul_start;
    logic             mul_done;
    logic             load_mul;
    logic [WIDTH-1:0] mul_p;

    assign is_mul = (op == ALU_MUL);

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (bus.in_a),
        .b     (bus.in_b),
        .done  (mul_done),
        .p     (mul_p)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        take          = 1'b0;
        load_alu      = 1'b0;
`ifdef ALU_MUL_EN
        mul_start     = 1'b0;
        load_mul      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                take         = bus.in_valid;
            end
            ST_BUSY: begin
`ifdef ALU_MUL_EN
                if (mul_done) begin
                    load_mul = 1'b1;
                    state_d  = ST_HOLD;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_HOLD: begin
                bus.out_valid = 1'b1;
                bus.in_ready  = bus.out_ready;
                take          = bus.out_ready && bus.in_valid;
                if (bus.out_ready && !bus.in_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (take) begin
`ifdef ALU_MUL_EN
            if (is_mul) begin
                mul_start = 1'b1;
                state_d   = ST_BUSY;
            end else begin
                load_alu = 1'b1;
                state_d  = ST_HOLD;
            end
`else
            load_alu = 1'b1;
            state_d  = ST_HOLD;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (load_alu) begin
            res_q  <= alu_res;
            zero_q <= (alu_res == '0);
            ovf_q  <= alu_ovf;
`ifdef ALU_MUL_EN
        end else if (load_mul) begin
            res_q  <= mul_p;
            zero_q <= (mul_p == '0);
            ovf_q  <= 1'b0;
`endif
        end
    end

    assign bus.out_result = res_q;
    assign bus.out_zero   = zero_q;
    assign bus.out_ovf    = ovf_q;

endmodule
